// File: rtl/sram_like_arbiter_pkg.sv
// rtl/sram_like_arbiter_pkg.sv - shared owner tags and lock state encodings for the SRAM-like arbiter
package sram_like_arbiter_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  typedef enum logic [1:0] {
    LOCK_IDLE   = 2'd0,
    LOCK_HOLD_I = 2'd1,
    LOCK_HOLD_D = 2'd2
  } lock_e;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// rtl/sram_like_arbiter_owner_fifo.sv - in-order 1-bit owner tag FIFO for outstanding requests
module sram_like_arbiter_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push_i,
  input  logic push_tag_i,
  input  logic pop_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] tags_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = tags_q[rd_ptr_q];

  // A pop on a full FIFO cannot be reused by a push in the same cycle; the caller never pushes when full.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Tag storage, pointers (wrap naturally since DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        tags_q[wr_ptr_q] <= push_tag_i;
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - shares one SRAM-like port between instruction and data requesters
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int STARVE_LIM  = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        rsp_err
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  lock_e         lock_q;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          rsp_err_q;
  logic          active_q;
  logic          grant_i;
  logic          grant_d;
  logic          winner_req;
  logic          accept;
  logic          fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          rsp_hit;

  // Outputs stay quiet until the first clock edge after reset has been released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) active_q <= 1'b0;
    else         active_q <= 1'b1;
  end

  // Grant selection: a locked master keeps the port; otherwise data first unless inst has starved.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (lock_q)
      LOCK_HOLD_I: grant_i = 1'b1;
      LOCK_HOLD_D: grant_d = 1'b1;
      default: begin
        if (data_req && !((starve_q == SW'(STARVE_LIM)) && inst_req)) grant_d = 1'b1;
        else if (inst_req)                                             grant_i = 1'b1;
      end
    endcase
  end

  assign winner_req   = (grant_i & inst_req) | (grant_d & data_req);
  assign mem_req      = active_q & winner_req & ~fifo_full;
  assign accept       = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept & grant_i;
  assign data_addr_ok = accept & grant_d;

  // Request fields follow the granted master; zero when nobody holds the port.
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (active_q && grant_d) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (active_q && grant_i) begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

  // Responses are steered by the oldest outstanding owner tag.
  assign rsp_hit      = active_q & mem_data_ok & ~fifo_empty;
  assign inst_data_ok = rsp_hit & (fifo_head == OWNER_INST);
  assign data_data_ok = rsp_hit & (fifo_head == OWNER_DATA);
  assign inst_rdata   = active_q ? mem_rdata : '0;
  assign data_rdata   = active_q ? mem_rdata : '0;
  assign rsp_err      = rsp_err_q;

  sram_like_arbiter_owner_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_owner_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push_i    (accept),
    .push_tag_i(grant_d ? OWNER_DATA : OWNER_INST),
    .pop_i     (active_q & mem_data_ok),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Starvation counter: counts consecutive refused inst cycles, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!active_q)                        starve_d = '0;
    else if (!inst_req || inst_addr_ok)   starve_d = '0;
    else if (starve_q != SW'(STARVE_LIM)) starve_d = starve_q + SW'(1);
  end

  // Lock FSM keeps the address phase stable until the slave accepts it or the master withdraws.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q <= LOCK_IDLE;
    end else begin
      case (lock_q)
        LOCK_IDLE:   if (mem_req && !mem_addr_ok) lock_q <= grant_d ? LOCK_HOLD_D : LOCK_HOLD_I;
        LOCK_HOLD_I: if (accept || !inst_req)     lock_q <= LOCK_IDLE;
        LOCK_HOLD_D: if (accept || !data_req)     lock_q <= LOCK_IDLE;
        default:                                  lock_q <= LOCK_IDLE;
      endcase
    end
  end

  // Starve counter and sticky error for a response with nothing outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      if (active_q && mem_data_ok && fifo_empty) rsp_err_q <= 1'b1;
    end
  end

endmodule
